// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data-memory controller.
package dmem_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Wait-state count is preloaded with LAT-1 because the accepting IDLE cycle is the first stall.
  function automatic logic [CntW-1:0] lat_to_cnt(input int unsigned lat);
    return CntW'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with write enable and a registered, enable-gated read port.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WordW-1:0] wdata_i,
  output logic [WordW-1:0] rdata_o
);

  logic [WordW-1:0] mem_q [2**AW];
  logic [WordW-1:0] rdata_q;

  // Read register samples the array before the write lands, so a same-edge read sees old data.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_waitstate_ctrl.sv
// Data-port memory controller: stalls the core for programmable wait states, then
// performs the load or store on an internal word RAM.
module dmem_waitstate_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned AW        = 6,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [31:0]      addr,
  input  logic [WordW-1:0] data_w,
  output logic [WordW-1:0] data_r,
  output logic             bus_wait,
  output logic             misalign
);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WordW-1:0] wdata_q, wdata_d;
  logic             is_store_q, is_store_d;
  logic             aligned_q, aligned_d;
  logic             misalign_q, misalign_d;
  logic [WordW-1:0] data_r_q, data_r_d;
  logic             load_hit_q, load_hit_d;
  logic             go_done;
  logic             ram_we, ram_re;
  logic [WordW-1:0] ram_rdata;
  logic             unused_addr;

  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    aligned_d  = aligned_q;
    misalign_d = misalign_q;
    data_r_d   = data_r_q;
    load_hit_d = 1'b0;
    go_done    = 1'b0;
    bus_wait   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (memread || memwrite) begin
          bus_wait   = 1'b1;
          idx_d      = addr[AW+1:2];
          wdata_d    = data_w;
          is_store_d = memwrite;
          aligned_d  = (addr[1:0] == 2'b00);
          if (addr[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
          cnt_d = memwrite ? lat_to_cnt(WRITE_LAT) : lat_to_cnt(READ_LAT);
          if (cnt_d == '0) begin
            go_done = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        bus_wait = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          go_done = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (load_hit_q) begin
          data_r_d = ram_rdata;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Loads complete on the edge entering DONE; a misaligned load reports zero.
    if (go_done && !is_store_d) begin
      if (aligned_d) begin
        load_hit_d = 1'b1;
      end else begin
        data_r_d = '0;
      end
    end

    if (reset) begin
      bus_wait = 1'b0;
    end
  end

  // RAM uses next-state request fields so a one-cycle access still hits the right word.
  assign ram_we = go_done && is_store_d && aligned_d && !reset;
  assign ram_re = go_done && !is_store_d && aligned_d && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      data_r_q   <= '0;
      load_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      data_r_q   <= data_r_d;
      load_hit_q <= load_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q      <= idx_d;
    wdata_q    <= wdata_d;
    is_store_q <= is_store_d;
    aligned_q  <= aligned_d;
  end

  dmem_ram #(
    .AW(AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (idx_d),
    .wdata_i (wdata_d),
    .rdata_o (ram_rdata)
  );

  // While the loaded word sits in the RAM read register, present it directly.
  assign data_r   = load_hit_q ? ram_rdata : data_r_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_waitstate_ctrl.sv
// Scoreboard bench: two controller instances (write latency 1 and 3) with a word-array model.
module tb_dmem_waitstate_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        a_reset = 1'b1, b_reset = 1'b1;
  logic        a_memread = 1'b0, a_memwrite = 1'b0, b_memread = 1'b0, b_memwrite = 1'b0;
  logic [31:0] a_addr = '0, a_data_w = '0, b_addr = '0, b_data_w = '0;
  logic [31:0] a_data_r, b_data_r;
  logic        a_bus_wait, b_bus_wait, a_misalign, b_misalign;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_a [64];
  logic [31:0] model_b [64];
  logic [31:0] sb_q [$];
  logic [31:0] last_load_a;

  always #5 clk = ~clk;

  dmem_waitstate_ctrl #(.AW(6), .READ_LAT(2), .WRITE_LAT(1)) dut_a (
    .clk(clk), .reset(a_reset), .memread(a_memread), .memwrite(a_memwrite), .addr(a_addr),
    .data_w(a_data_w), .data_r(a_data_r), .bus_wait(a_bus_wait), .misalign(a_misalign)
  );

  dmem_waitstate_ctrl #(.AW(6), .READ_LAT(2), .WRITE_LAT(3)) dut_b (
    .clk(clk), .reset(b_reset), .memread(b_memread), .memwrite(b_memwrite), .addr(b_addr),
    .data_w(b_data_w), .data_r(b_data_r), .bus_wait(b_bus_wait), .misalign(b_misalign)
  );

  // One access: drives the request, counts stall cycles, pops/compares load data in DONE.
  task automatic access(input bit b, input bit rd, input bit wr, input logic [31:0] ad,
                        input logic [31:0] dw, input int exp_lat, input bit keep,
                        input string name);
    int          n;
    logic        bw;
    logic [31:0] exp_d, got_d;
    logic [5:0]  idx;
    idx = ad[7:2];
    @(posedge clk); #1;
    if (b) begin b_memread = rd; b_memwrite = wr; b_addr = ad; b_data_w = dw; end
    else   begin a_memread = rd; a_memwrite = wr; a_addr = ad; a_data_w = dw; end
    if (wr) begin
      if (ad[1:0] == 2'b00) begin
        if (b) model_b[idx] = dw; else model_a[idx] = dw;
      end
    end else begin
      if (ad[1:0] != 2'b00) sb_q.push_back(32'h0);
      else sb_q.push_back(b ? model_b[idx] : model_a[idx]);
    end
    n = 0;
    @(negedge clk);
    bw = b ? b_bus_wait : a_bus_wait;
    while (bw && n < 40) begin
      n++;
      @(negedge clk);
      bw = b ? b_bus_wait : a_bus_wait;
    end
    tests_run++;
    if (n !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, n, exp_lat);
    end
    if (!wr) begin
      exp_d = sb_q.pop_front();
      got_d = b ? b_data_r : a_data_r;
      if (!b) last_load_a = exp_d;
      tests_run++;
      if (got_d !== exp_d) begin
        tests_failed++;
        $display("FAIL %s data_r: got %h, want %h", name, got_d, exp_d);
      end
    end
    if (!keep) begin
      @(posedge clk); #1;
      if (b) begin b_memread = 1'b0; b_memwrite = 1'b0; end
      else   begin a_memread = 1'b0; a_memwrite = 1'b0; end
    end
  endtask

  task automatic check_a(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    a_memread = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_a("reset bus_wait forced low", {31'b0, a_bus_wait}, 32'h0);
    check_a("reset data_r", a_data_r, 32'h0);
    check_a("reset misalign", {31'b0, a_misalign}, 32'h0);
    @(posedge clk); #1;
    a_memread = 1'b0;
    a_reset = 1'b0;
    b_reset = 1'b0;
  endtask

  task automatic test_store_load();
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 1, 0, "store@10");
    access(0, 1, 0, 32'h10, 32'h0, 2, 0, "load@10");
    @(negedge clk);
    check_a("data_r held after load", a_data_r, 32'hDEADBEEF);
  endtask

  task automatic test_back_to_back();
    access(0, 0, 1, 32'h0, 32'h01010101, 1, 0, "store@0");
    access(0, 0, 1, 32'h4, 32'h02020202, 1, 0, "store@4");
    access(0, 1, 0, 32'h0, 32'h0, 2, 1, "b2b load@0");
    access(0, 1, 0, 32'h4, 32'h0, 2, 0, "b2b load@4");
  endtask

  task automatic test_misalign();
    check_a("misalign clear before", {31'b0, a_misalign}, 32'h0);
    access(0, 1, 0, 32'h3, 32'h0, 2, 0, "load@3");
    check_a("misalign set", {31'b0, a_misalign}, 32'h1);
    access(0, 0, 1, 32'h2, 32'hFFFFFFFF, 1, 0, "misaligned store@2");
    access(0, 1, 0, 32'h0, 32'h0, 2, 0, "load@0 unchanged");
    check_a("misalign sticky", {31'b0, a_misalign}, 32'h1);
  endtask

  task automatic test_both_high();
    access(0, 1, 1, 32'h8, 32'h12345678, 1, 0, "rd+wr@8");
    check_a("data_r unchanged by rd+wr", a_data_r, last_load_a);
    access(0, 1, 0, 32'h8, 32'h0, 2, 0, "load@8");
  endtask

  task automatic test_wrap();
    access(0, 0, 1, 32'h100, 32'hCAFEF00D, 1, 0, "store@100");
    access(0, 1, 0, 32'h0, 32'h0, 2, 0, "load@0 wrapped");
    @(posedge clk); #1;
    a_reset = 1'b1;
    @(posedge clk); #1;
    a_reset = 1'b0;
    @(negedge clk);
    check_a("misalign cleared by reset", {31'b0, a_misalign}, 32'h0);
    check_a("data_r cleared by reset", a_data_r, 32'h0);
  endtask

  task automatic test_reset_abort();
    access(1, 0, 1, 32'h20, 32'h11112222, 3, 0, "B store@20");
    @(posedge clk); #1;
    b_memwrite = 1'b1; b_addr = 32'h20; b_data_w = 32'hAAAA5555;
    @(posedge clk); #1;
    b_reset = 1'b1;
    @(negedge clk);
    check_a("bus_wait low during reset", {31'b0, b_bus_wait}, 32'h0);
    @(posedge clk); #1;
    b_reset = 1'b0;
    b_memwrite = 1'b0;
    @(negedge clk);
    check_a("bus_wait low after abort", {31'b0, b_bus_wait}, 32'h0);
    check_a("state idle after abort", {30'b0, dut_b.state_q}, {30'b0, StIdle});
    access(1, 1, 0, 32'h20, 32'h0, 2, 0, "B load@20 prior");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_misalign();
    test_both_high();
    test_wrap();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
